// File: rtl/math_rp_checker.sv
// Built-in self-test for the multiplier reconfigurable partition: sweeps every
// operand pair, checks the registered product and records the first failure.
module math_rp_checker #(
    parameter int unsigned OP_WIDTH  = 4,
    parameter int unsigned RES_WIDTH = 8,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_vio,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RES_WIDTH-1:0] rp_out,
    output logic [OP_WIDTH-1:0]  in1,
    output logic [OP_WIDTH-1:0]  in2,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [OP_WIDTH-1:0]  first_err_in1,
    output logic [OP_WIDTH-1:0]  first_err_in2,
    output logic [RES_WIDTH-1:0] first_err_got
);

    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]    in1_q, in1_d, in2_q, in2_d;
    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;
    logic [OP_WIDTH-1:0]    fe_in1_q, fe_in1_d, fe_in2_q, fe_in2_d;
    logic [RES_WIDTH-1:0]   fe_got_q, fe_got_d;
    logic                   fe_seen_q, fe_seen_d;
    logic [RES_WIDTH-1:0]   expected_c;
    logic                   last_vec_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        fe_in1_d   = fe_in1_q;
        fe_in2_d   = fe_in2_q;
        fe_got_d   = fe_got_q;
        fe_seen_d  = fe_seen_q;
        expected_c = RES_WIDTH'(in1_q) * RES_WIDTH'(in2_q);
        last_vec_c = (&in1_q) && (&in2_q);

        // Abort beats every other action while a sweep is running.
        if (busy_q && abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d   = S_DRIVE;
                        in1_d     = '0;
                        in2_d     = '0;
                        err_d     = '0;
                        fe_in1_d  = '0;
                        fe_in2_d  = '0;
                        fe_got_d  = '0;
                        fe_seen_d = 1'b0;
                        done_d    = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
                S_DRIVE: begin
                    cnt_d   = CNT_WIDTH'(LATENCY - 1);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
                S_CHECK: begin
                    if (rp_out != expected_c) begin
                        if (!(&err_q)) begin
                            err_d = err_q + ERR_WIDTH'(1);
                        end
                        if (!fe_seen_q) begin
                            fe_seen_d = 1'b1;
                            fe_in1_d  = in1_q;
                            fe_in2_d  = in2_q;
                            fe_got_d  = rp_out;
                        end
                    end
                    if (last_vec_c) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                        in2_d   = in2_q + OP_WIDTH'(1);
                        if (&in2_q) begin
                            in1_d = in1_q + OP_WIDTH'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or posedge reset_vio) begin
        if (reset_vio) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fe_in1_q  <= '0;
            fe_in2_q  <= '0;
            fe_got_q  <= '0;
            fe_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fe_in1_q  <= fe_in1_d;
            fe_in2_q  <= fe_in2_d;
            fe_got_q  <= fe_got_d;
            fe_seen_q <= fe_seen_d;
        end
    end

    assign in1           = in1_q;
    assign in2           = in2_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_in1 = fe_in1_q;
    assign first_err_in2 = fe_in2_q;
    assign first_err_got = fe_got_q;

endmodule

// File: tb/tb_math_rp_checker.sv
// Bench for math_rp_checker: checker instances at latency 1 and 3, each
// driving a behavioural RP multiplier with an optional stuck-at-0 product bit.
module tb_math_rp_checker;

    logic        clk = 1'b0;
    logic        reset_vio = 1'b1;
    logic        start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic        stuck = 1'b0;
    logic        use3 = 1'b0;
    logic [7:0]  rp1, rp3, p3a, p3b;
    logic [3:0]  in1_1, in2_1, fe1_1, fe2_1, in1_3, in2_3, fe1_3, fe2_3;
    logic        busy_1, done_1, pass_1, busy_3, done_3, pass_3;
    logic [15:0] err_1, err_3;
    logic [7:0]  feg_1, feg_3;

    logic [3:0]  s_in1, s_in2, s_fe1, s_fe2;
    logic        s_busy, s_done, s_pass;
    logic [15:0] s_err;
    logic [7:0]  s_feg, mask;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    math_rp_checker #(.OP_WIDTH(4), .RES_WIDTH(8), .LATENCY(1), .ERR_WIDTH(16)) dut1 (
        .clk(clk), .reset_vio(reset_vio), .start(start1), .abort(abort1), .rp_out(rp1),
        .in1(in1_1), .in2(in2_1), .busy(busy_1), .done(done_1), .pass(pass_1),
        .err_count(err_1), .first_err_in1(fe1_1), .first_err_in2(fe2_1),
        .first_err_got(feg_1));

    math_rp_checker #(.OP_WIDTH(4), .RES_WIDTH(8), .LATENCY(3), .ERR_WIDTH(16)) dut3 (
        .clk(clk), .reset_vio(reset_vio), .start(start3), .abort(abort3), .rp_out(rp3),
        .in1(in1_3), .in2(in2_3), .busy(busy_3), .done(done_3), .pass(pass_3),
        .err_count(err_3), .first_err_in1(fe1_3), .first_err_in2(fe2_3),
        .first_err_got(feg_3));

    // Behavioural RP: 1-stage and 3-stage registered multipliers.
    assign mask = stuck ? 8'hFE : 8'hFF;
    always_ff @(posedge clk) begin
        rp1 <= (8'(in1_1) * 8'(in2_1)) & mask;
        p3a <= (8'(in1_3) * 8'(in2_3)) & mask;
        p3b <= p3a;
        rp3 <= p3b;
    end

    always_comb begin
        s_in1  = use3 ? in1_3  : in1_1;
        s_in2  = use3 ? in2_3  : in2_1;
        s_fe1  = use3 ? fe1_3  : fe1_1;
        s_fe2  = use3 ? fe2_3  : fe2_1;
        s_feg  = use3 ? feg_3  : feg_1;
        s_busy = use3 ? busy_3 : busy_1;
        s_done = use3 ? done_3 : done_1;
        s_pass = use3 ? pass_3 : pass_1;
        s_err  = use3 ? err_3  : err_1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start1 = !use3;
        start3 = use3;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts edges after the start edge until done; optionally pulses start/abort at edge i.
    task automatic run_until(input int start_at, input int abort_at, input int limit,
                             output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            start1 = !use3 && (i == start_at);
            start3 = use3 && (i == start_at);
            abort1 = !use3 && (i == abort_at);
            abort3 = use3 && (i == abort_at);
            @(posedge clk);
            n = i;
            #1;
            start1 = 1'b0; start3 = 1'b0; abort1 = 1'b0; abort3 = 1'b0;
            if (s_done || i == abort_at) break;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in1"}, int'(s_in1), 0);
        chk({tag, "_in2"}, int'(s_in2), 0);
        chk({tag, "_busy"}, int'(s_busy), 0);
        chk({tag, "_done"}, int'(s_done), 0);
        chk({tag, "_pass"}, int'(s_pass), 0);
        chk({tag, "_err"}, int'(s_err), 0);
        chk({tag, "_fe1"}, int'(s_fe1), 0);
        chk({tag, "_fe2"}, int'(s_fe2), 0);
        chk({tag, "_feg"}, int'(s_feg), 0);
    endtask

    typedef struct {
        bit u3;
        bit stk;
        int cycles;
        int errs;
        int fe1;
        int fe2;
        int feg;
        int ps;
    } vec_t;

    vec_t vecs[4];
    int   n;

    initial begin
        vecs[0] = '{1'b0, 1'b0,  768,  0, 0, 0, 0, 1};
        vecs[1] = '{1'b0, 1'b1,  768, 64, 1, 1, 0, 0};
        vecs[2] = '{1'b1, 1'b0, 1280,  0, 0, 0, 0, 1};
        vecs[3] = '{1'b1, 1'b1, 1280, 64, 1, 1, 0, 0};

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_vio = 1'b0;

        // Full sweeps from the table.
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            use3  = vecs[v].u3;
            stuck = vecs[v].stk;
            pulse_start();
            chk("busy_rise", int'(s_busy), 1);
            run_until(0, 0, 3000, n);
            chk("sweep_cycles", n, vecs[v].cycles);
            chk("done", int'(s_done), 1);
            chk("busy_end", int'(s_busy), 0);
            chk("pass", int'(s_pass), vecs[v].ps);
            chk("err_count", int'(s_err), vecs[v].errs);
            chk("first_in1", int'(s_fe1), vecs[v].fe1);
            chk("first_in2", int'(s_fe2), vecs[v].fe2);
            chk("first_got", int'(s_feg), vecs[v].feg);
            chk("end_in1", int'(s_in1), 15);
            chk("end_in2", int'(s_in2), 15);
            repeat (3) @(posedge clk);
            #1;
            chk("done_held", int'(s_done), 1);
        end

        // Second start 50 cycles into a golden sweep is ignored.
        @(negedge clk);
        use3 = 1'b0;
        stuck = 1'b0;
        pulse_start();
        run_until(50, 0, 3000, n);
        chk("restart_cycles", n, 768);
        chk("restart_err", int'(s_err), 0);
        chk("restart_pass", int'(s_pass), 1);

        // Async reset mid-sweep around vector 100, then a clean sweep.
        @(negedge clk);
        stuck = 1'b1;
        pulse_start();
        run_until(0, 0, 300, n);
        chk("pre_reset_busy", int'(s_busy), 1);
        #2;
        reset_vio = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset_vio = 1'b0;
        stuck = 1'b0;
        pulse_start();
        run_until(0, 0, 3000, n);
        chk("post_reset_cycles", n, 768);
        chk("post_reset_err", int'(s_err), 0);
        chk("post_reset_pass", int'(s_pass), 1);

        // Abort during the drive of vector 40 with the stuck-bit RP.
        @(negedge clk);
        stuck = 1'b1;
        pulse_start();
        run_until(0, 121, 3000, n);
        chk("abort_edge", n, 121);
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_done", int'(s_done), 0);
        chk("abort_err", int'(s_err), 8);
        chk("abort_in1", int'(s_in1), 2);
        chk("abort_in2", int'(s_in2), 8);
        chk("abort_fe1", int'(s_fe1), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_idle_busy", int'(s_busy), 0);
        chk("abort_idle_err", int'(s_err), 8);
        pulse_start();
        chk("after_abort_clear", int'(s_err), 0);
        run_until(0, 0, 3000, n);
        chk("after_abort_cycles", n, 768);
        chk("after_abort_err", int'(s_err), 64);
        chk("after_abort_pass", int'(s_pass), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
